// File: rtl/pi1_rr_arbiter_pkg.sv
// Purpose : shared PerInt (pi1) definitions for the round-robin arbiter slice.
//           The op encodings, an enum view of them, and a helper that says
//           whether an op is a real request.
// Ports   : none (package).
package pi1_rr_arbiter_pkg;

  localparam logic [1:0] PINOOP = 2'b00;
  localparam logic [1:0] PIWROP = 2'b01;
  localparam logic [1:0] PIRDOP = 2'b10;
  localparam logic [1:0] PIRWOP = 2'b11;

  typedef enum logic [1:0] {
    OP_NOOP = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_RW   = 2'b11
  } pi1_op_e;

  // Any op other than NOOP competes for the slave.
  function automatic logic is_req(input logic [1:0] op);
    return (op != PINOOP);
  endfunction

endpackage

// File: rtl/pi1_rr_arbiter_pick.sv
// Purpose : combinational round-robin pick. The request vector is rotated so
//           that the master after 'last' comes first. The rotated vector is
//           priority-encoded, and the hit position is mapped back to a master
//           index.
// Ports   : req_i   - one request bit per master
//           last_i  - most recent winner (lowest priority this time)
//           found_o - at least one master is requesting
//           idx_o   - index of the chosen master (valid when found_o)
module pi1_rr_pick #(
  parameter int  MASTERCOUNT = 4,
  localparam int IDXW        = $clog2(MASTERCOUNT)
) (
  input  logic [MASTERCOUNT-1:0] req_i,
  input  logic [IDXW-1:0]        last_i,
  output logic                   found_o,
  output logic [IDXW-1:0]        idx_o
);

  logic [MASTERCOUNT-1:0] rot_s;
  logic [IDXW-1:0]        src_s [MASTERCOUNT];
  logic [IDXW-1:0]        hit_s;

  // base+off modulo MASTERCOUNT. A single subtraction is enough because
  // base < MASTERCOUNT and off <= MASTERCOUNT. This also keeps the wrap correct
  // for non-power-of-2 counts.
  function automatic logic [IDXW-1:0] wrap_idx(input logic [IDXW-1:0] base, input int off);
    int pos;
    pos = int'(base) + off;
    if (pos >= MASTERCOUNT) begin
      pos = pos - MASTERCOUNT;
    end else begin
      pos = pos;
    end
    return IDXW'(pos);
  endfunction

  // Rotate: slot k of the rotated vector holds master last+1+k.
  always_comb begin
    rot_s = '0;
    for (int k = 0; k < MASTERCOUNT; k++) begin
      src_s[k] = wrap_idx(last_i, k + 1);
      rot_s[k] = req_i[src_s[k]];
    end
  end

  // Priority-encode the lowest set slot, then map that slot back to a master.
  always_comb begin
    found_o = 1'b0;
    hit_s   = '0;
    for (int k = 0; k < MASTERCOUNT; k++) begin
      if (rot_s[k] && !found_o) begin
        found_o = 1'b1;
        hit_s   = IDXW'(k);
      end else begin
        found_o = found_o;
      end
    end
    idx_o = src_s[hit_s];
  end

endmodule

// File: rtl/pi1_rr_arbiter.sv
// Purpose : round-robin arbiter that shares one pi1 slave port between
//           MASTERCOUNT pi1 masters. Grant is zero-latency. It remembers which
//           master owns the single outstanding op, so that the slave response
//           (the next s_rdy_i cycle) is acknowledged only to that master.
// Ports   : clk_i/rst_i          - clock, synchronous active-high reset
//           m_op_i/m_addr_i/m_data_i/m_sel_i - packed per-master requests
//           m_data_o             - slave read data broadcast to all masters
//           m_rdy_o              - per-master ready (accept, response or idle)
//           s_op_o/s_addr_o/s_data_o/s_sel_o - request to the slave
//           s_data_i/s_rdy_i     - slave response data and ready
module pi1_rr_arbiter
  import pi1_rr_arbiter_pkg::*;
#(
  parameter int  MASTERCOUNT = 4,
  parameter int  ARCHBITSZ   = 32,
  localparam int ADDRBITSZ   = ARCHBITSZ - $clog2(ARCHBITSZ / 8),
  localparam int SELW        = ARCHBITSZ / 8,
  localparam int IDXW        = $clog2(MASTERCOUNT)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [2*MASTERCOUNT-1:0]      m_op_i,
  input  logic [ADDRBITSZ*MASTERCOUNT-1:0] m_addr_i,
  input  logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_i,
  input  logic [SELW*MASTERCOUNT-1:0]   m_sel_i,
  output logic [ARCHBITSZ-1:0]          m_data_o,
  output logic [MASTERCOUNT-1:0]        m_rdy_o,
  output logic [1:0]                    s_op_o,
  output logic [ADDRBITSZ-1:0]          s_addr_o,
  output logic [ARCHBITSZ-1:0]          s_data_o,
  output logic [SELW-1:0]               s_sel_o,
  input  logic [ARCHBITSZ-1:0]          s_data_i,
  input  logic                          s_rdy_i
);

  logic                   pending_q, pending_d;
  logic [IDXW-1:0]        owner_q,   owner_d;
  logic [IDXW-1:0]        last_q,    last_d;

  logic [MASTERCOUNT-1:0] req_s;
  logic                   found_s;
  logic [IDXW-1:0]        win_s;
  logic                   grant_s;

  // One request bit per master.
  always_comb begin
    req_s = '0;
    for (int i = 0; i < MASTERCOUNT; i++) begin
      req_s[i] = is_req(m_op_i[2*i +: 2]);
    end
  end

  pi1_rr_pick #(
    .MASTERCOUNT (MASTERCOUNT)
  ) u_pick (
    .req_i   (req_s),
    .last_i  (last_q),
    .found_o (found_s),
    .idx_o   (win_s)
  );

  // An op goes to the slave only when the slave takes it and we are out of reset.
  assign grant_s  = found_s && s_rdy_i && !rst_i;
  assign m_data_o = s_data_i;

  // Slave request mux. When idle, master 0's fields pass through with a NOOP op.
  always_comb begin
    s_op_o   = PINOOP;
    s_addr_o = m_addr_i[0 +: ADDRBITSZ];
    s_data_o = m_data_i[0 +: ARCHBITSZ];
    s_sel_o  = m_sel_i[0 +: SELW];
    if (grant_s) begin
      s_op_o   = m_op_i[2*win_s +: 2];
      s_addr_o = m_addr_i[ADDRBITSZ*win_s +: ADDRBITSZ];
      s_data_o = m_data_i[ARCHBITSZ*win_s +: ARCHBITSZ];
      s_sel_o  = m_sel_i[SELW*win_s +: SELW];
    end else begin
      s_op_o   = PINOOP;
    end
  end

  // Per-master ready. A master is ready if it is accepted now, if its response
  // lands now, or if it is idle and owed nothing. An idle owner must wait for
  // its response.
  always_comb begin
    m_rdy_o = '0;
    for (int i = 0; i < MASTERCOUNT; i++) begin
      if (s_rdy_i && !rst_i) begin
        m_rdy_o[i] = (grant_s && (win_s == IDXW'(i)))
                   || (pending_q && (owner_q == IDXW'(i)))
                   || (!req_s[i] && !(pending_q && (owner_q == IDXW'(i))));
      end else begin
        m_rdy_o[i] = 1'b0;
      end
    end
  end

  // State update. It advances only on slave-ready cycles. With no winner the
  // outstanding op retires, and owner/last hold.
  always_comb begin
    pending_d = pending_q;
    owner_d   = owner_q;
    last_d    = last_q;
    if (s_rdy_i) begin
      if (found_s) begin
        pending_d = 1'b1;
        owner_d   = win_s;
        last_d    = win_s;
      end else begin
        pending_d = 1'b0;
      end
    end else begin
      pending_d = pending_q;
    end
  end

  // State registers. After reset, last points at the top master, so master 0 wins first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= 1'b0;
      owner_q   <= '0;
      last_q    <= IDXW'(MASTERCOUNT - 1);
    end else begin
      pending_q <= pending_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
    end
  end

endmodule

// File: tb/tb_pi1_rr_arbiter.sv
module tb_pi1_rr_arbiter;

  localparam int MC = 4;
  localparam int DW = 32;
  localparam int AW = 30;
  localparam int SW = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [2*MC-1:0]   m_op_i;
  logic [AW*MC-1:0]  m_addr_i;
  logic [DW*MC-1:0]  m_data_i;
  logic [SW*MC-1:0]  m_sel_i;
  logic [DW-1:0]     m_data_o;
  logic [MC-1:0]     m_rdy_o;
  logic [1:0]        s_op_o;
  logic [AW-1:0]     s_addr_o;
  logic [DW-1:0]     s_data_o;
  logic [SW-1:0]     s_sel_o;
  logic [DW-1:0]     s_data_i;
  logic              s_rdy_i;

  always #5 clk_i = ~clk_i;

  pi1_rr_arbiter #(.MASTERCOUNT(MC), .ARCHBITSZ(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_op_i(m_op_i), .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_sel_i(m_sel_i),
    .m_data_o(m_data_o), .m_rdy_o(m_rdy_o),
    .s_op_o(s_op_o), .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o),
    .s_data_i(s_data_i), .s_rdy_i(s_rdy_i)
  );

  typedef struct {
    logic [1:0]    s_op;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data;
    logic [SW-1:0] s_sel;
    logic [MC-1:0] m_rdy;
    bit            chk_data;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference model: who goes next, who is owed a response, and a small slave memory.
  int            mdl_last;
  int            mdl_owner;
  bit            mdl_pend;
  bit            resp_rd;
  logic [DW-1:0] resp_val;
  logic [DW-1:0] mem [8];

  // Master-side request state; a request is held until the model grants it.
  logic [1:0]    mop   [MC];
  logic [AW-1:0] maddr [MC];
  logic [DW-1:0] mdata [MC];
  logic [SW-1:0] msel  [MC];

  task automatic new_req(input int i, input int p_req, input logic [MC-1:0] allow);
    maddr[i] = AW'($urandom_range(7));
    mdata[i] = $urandom;
    msel[i]  = SW'($urandom_range(15));
    if (allow[i] && ($urandom_range(99) < p_req)) mop[i] = 2'($urandom_range(3, 1));
    else mop[i] = 2'b00;
  endtask

  task automatic run_phase(input int n, input int p_req, input int p_rdy, input int p_rst,
                           input logic [MC-1:0] allow);
    exp_t e;
    int   win;
    int   c;
    logic [2:0] a;
    for (int cyc = 0; cyc < n; cyc++) begin
      @(posedge clk_i);
      #1;
      rst_i   = ($urandom_range(99) < p_rst);
      s_rdy_i = ($urandom_range(99) < p_rdy);
      s_data_i = mdl_pend ? resp_val : $urandom;
      for (int i = 0; i < MC; i++) begin
        m_op_i[2*i +: 2]     = mop[i];
        m_addr_i[AW*i +: AW] = maddr[i];
        m_data_i[DW*i +: DW] = mdata[i];
        m_sel_i[SW*i +: SW]  = msel[i];
      end
      // Winner: first requester after the last winner, wrapping around the masters.
      win = -1;
      if (!rst_i && s_rdy_i) begin
        for (int k = 1; k <= MC; k++) begin
          c = (mdl_last + k) % MC;
          if (mop[c] != 2'b00 && win < 0) win = c;
        end
      end
      e.s_op     = (win >= 0) ? mop[win] : 2'b00;
      e.s_addr   = (win >= 0) ? maddr[win] : '0;
      e.s_data   = (win >= 0) ? mdata[win] : '0;
      e.s_sel    = (win >= 0) ? msel[win] : '0;
      e.m_rdy    = '0;
      e.chk_data = 1'b0;
      e.data     = resp_val;
      if (!rst_i && s_rdy_i) begin
        for (int i = 0; i < MC; i++) begin
          e.m_rdy[i] = (i == win) || (mdl_pend && mdl_owner == i)
                     || (mop[i] == 2'b00 && !(mdl_pend && mdl_owner == i));
        end
        e.chk_data = mdl_pend && resp_rd;
      end
      sb_q.push_back(e);
      // Advance the model.
      if (rst_i) begin
        mdl_pend = 1'b0; mdl_owner = 0; mdl_last = MC - 1;
      end else if (s_rdy_i) begin
        if (win >= 0) begin
          a = maddr[win][2:0];
          resp_rd  = (mop[win] == 2'b10) || (mop[win] == 2'b11);
          resp_val = mem[a];
          if (mop[win] == 2'b01 || mop[win] == 2'b11) begin
            for (int b = 0; b < SW; b++)
              if (msel[win][b]) mem[a][8*b +: 8] = mdata[win][8*b +: 8];
          end
          mdl_pend = 1'b1; mdl_owner = win; mdl_last = win;
          new_req(win, p_req, allow);
        end else begin
          mdl_pend = 1'b0;
        end
      end
      for (int i = 0; i < MC; i++)
        if (mop[i] == 2'b00) new_req(i, p_req, allow);
    end
  endtask

  // Monitor: compares the DUT outputs with the oldest expected entry in mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_vec++;
        if (s_op_o !== e.s_op) begin
          n_miss++; $display("FAIL s_op t=%0t got %b exp %b", $time, s_op_o, e.s_op);
        end
        if (m_rdy_o !== e.m_rdy) begin
          n_miss++; $display("FAIL m_rdy t=%0t got %b exp %b", $time, m_rdy_o, e.m_rdy);
        end
        if (e.s_op != 2'b00) begin
          if (s_addr_o !== e.s_addr || s_data_o !== e.s_data || s_sel_o !== e.s_sel) begin
            n_miss++;
            $display("FAIL s_fields t=%0t got %h/%h/%h exp %h/%h/%h", $time,
                     s_addr_o, s_data_o, s_sel_o, e.s_addr, e.s_data, e.s_sel);
          end
        end
        if (e.chk_data && m_data_o !== e.data) begin
          n_miss++; $display("FAIL m_data t=%0t got %h exp %h", $time, m_data_o, e.data);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'hDEAD_BE00 + 32'(i * 17);
    for (int i = 0; i < MC; i++) begin
      mop[i] = 2'b00; maddr[i] = '0; mdata[i] = '0; msel[i] = '0;
    end
    mdl_pend = 1'b0; mdl_owner = 0; mdl_last = MC - 1; resp_rd = 1'b0; resp_val = '0;
    rst_i = 1'b1; s_rdy_i = 1'b0; s_data_i = '0;
    m_op_i = '0; m_addr_i = '0; m_data_i = '0; m_sel_i = '0;

    run_phase(4,   60, 100, 100, 4'hF); // held in reset, requests present
    run_phase(40, 100, 100,   0, 4'hF); // everyone always requesting
    run_phase(300, 60,  70,   0, 4'hF); // mixed traffic
    run_phase(200, 40,  30,   0, 4'hF); // slow slave
    run_phase(300, 50,  60,   4, 4'hF); // resets mid-op
    run_phase(100, 100, 85,   0, 4'b0010); // single requester back-to-back
    run_phase(150, 70,  50,   0, 4'b1011); // m2 idle

    repeat (3) @(negedge clk_i);
    if (sb_q.size() != 0) begin
      n_miss++; $display("FAIL drain leftover=%0d exp 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
